// File: rtl/alu_pkg.sv
// Shared definitions for the EX/ID arithmetic block: datapath width, ALU opcodes
// and the signed-overflow helper used when ALU_OVERFLOW_EN is defined.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_OR  = 2'b11;

  // SUB is ADD with B's sign inverted; overflow when effective signs agree and result flips.
  function automatic logic signedOverflow(input logic aSign, input logic bSign,
                                          input logic rSign, input logic isSub);
    logic bEffSign;
    bEffSign = bSign ^ isSub;
    return (aSign == bEffSign) && (rSign != aSign);
  endfunction

endpackage

// File: rtl/wrap_adder.sv
// Plain WIDTH-bit unsigned adder; carry-out is dropped so the sum wraps.
module wrap_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_adder_comparator.sv
// EX ALU with registered EX/MEM capture, IF PC+1 adder, ID branch-target adder and
// ID equality comparator. Optional signed overflow outputs under macro ALU_OVERFLOW_EN.
module alu_adder_comparator
  import alu_pkg::*;
#(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int PC_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  input  logic             ex_hold,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             zero_q,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_plus_one,
  input  logic [WIDTH-1:0] pc_plus_one_id,
  input  logic [WIDTH-1:0] offset_ext,
  output logic [WIDTH-1:0] branch_address,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic             branch,
  output logic             equal_flag,
  output logic             branch_taken
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow,
  output logic             overflow_q
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP_W = WIDTH'(PC_STEP);

  alu_op_t          aluOp;
  logic [WIDTH-1:0] aluResultS;
  logic [1:0]       rstSyncR;
  logic             rstInt;

  assign aluOp = alu_op_t'(alu_control);

  // ALU datapath: all four operations wrap modulo 2^WIDTH.
  always_comb begin
    aluResultS = {WIDTH{1'b0}};
    case (aluOp)
      ALU_ADD: aluResultS = operand1 + operand2;
      ALU_SUB: aluResultS = operand1 - operand2;
      ALU_AND: aluResultS = operand1 & operand2;
      ALU_OR:  aluResultS = operand1 | operand2;
      default: aluResultS = {WIDTH{1'b0}};
    endcase
  end

  assign alu_result = aluResultS;
  assign zero       = ~|aluResultS;

  wrap_adder #(.WIDTH(WIDTH)) pcIncAdder (
    .a   (pc_in),
    .b   (PC_STEP_W),
    .sum (pc_plus_one)
  );

  // Word-addressed memory: the offset is added unshifted.
  wrap_adder #(.WIDTH(WIDTH)) branchTgtAdder (
    .a   (pc_plus_one_id),
    .b   (offset_ext),
    .sum (branch_address)
  );

  assign equal_flag   = (cmp_a == cmp_b);
  assign branch_taken = branch & equal_flag;

  // Reset bridge: asserts immediately, releases two clock edges after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstSyncR <= 2'b11;
    end else begin
      rstSyncR <= {rstSyncR[0], 1'b0};
    end
  end

  assign rstInt = rstSyncR[1];

  // EX/MEM capture of result and zero flag; ex_hold freezes, reset overrides hold.
  always_ff @(posedge clk or posedge rstInt) begin
    if (rstInt) begin
      alu_result_q <= {WIDTH{1'b0}};
      zero_q       <= 1'b0;
    end else if (!ex_hold) begin
      alu_result_q <= aluResultS;
      zero_q       <= zero;
    end else begin
      alu_result_q <= alu_result_q;
      zero_q       <= zero_q;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic overflowS;

  // Signed overflow only has meaning for the arithmetic ops.
  always_comb begin
    overflowS = 1'b0;
    case (aluOp)
      ALU_ADD: overflowS = signedOverflow(operand1[WIDTH-1], operand2[WIDTH-1],
                                          aluResultS[WIDTH-1], 1'b0);
      ALU_SUB: overflowS = signedOverflow(operand1[WIDTH-1], operand2[WIDTH-1],
                                          aluResultS[WIDTH-1], 1'b1);
      default: overflowS = 1'b0;
    endcase
  end

  assign overflow = overflowS;

  // Overflow capture follows the same reset/hold rules as the result register.
  always_ff @(posedge clk or posedge rstInt) begin
    if (rstInt) begin
      overflow_q <= 1'b0;
    end else if (!ex_hold) begin
      overflow_q <= overflowS;
    end else begin
      overflow_q <= overflow_q;
    end
  end
`endif

endmodule

// File: tb/tb_alu_adder_comparator.sv
// Scoreboard bench for alu_adder_comparator: stimulus pushes expectations, a negedge
// monitor pops and compares. Define ALU_OVERFLOW_EN to also cover the overflow outputs.
module tb_alu_adder_comparator;
  import alu_pkg::*;

  localparam int K_RES = 0, K_ZERO = 1, K_Q = 2, K_ZQ = 3, K_PC = 4, K_BA = 5,
                 K_EQ = 6, K_TK = 7, K_OV = 8, K_OVQ = 9;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk, rst;
  logic [31:0] operand1, operand2, pc_in, pc_plus_one_id, offset_ext, cmp_a, cmp_b;
  logic [1:0]  alu_control;
  logic        ex_hold, branch;
  logic [31:0] alu_result, alu_result_q, pc_plus_one, branch_address;
  logic        zero, zero_q, equal_flag, branch_taken;
`ifdef ALU_OVERFLOW_EN
  logic        overflow, overflow_q;
`endif

  item_t       sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] expQ;
  logic        expZq, expOq;

  alu_adder_comparator dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2),
    .alu_control(alu_control), .alu_result(alu_result), .zero(zero),
    .ex_hold(ex_hold), .alu_result_q(alu_result_q), .zero_q(zero_q),
    .pc_in(pc_in), .pc_plus_one(pc_plus_one), .pc_plus_one_id(pc_plus_one_id),
    .offset_ext(offset_ext), .branch_address(branch_address),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .branch(branch),
    .equal_flag(equal_flag), .branch_taken(branch_taken)
`ifdef ALU_OVERFLOW_EN
    , .overflow(overflow), .overflow_q(overflow_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  // Monitor: outputs are presented every cycle; check whatever is pending at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it = sb.pop_front();
      case (it.kind)
        K_RES:   act = alu_result;
        K_ZERO:  act = {31'd0, zero};
        K_Q:     act = alu_result_q;
        K_ZQ:    act = {31'd0, zero_q};
        K_PC:    act = pc_plus_one;
        K_BA:    act = branch_address;
        K_EQ:    act = {31'd0, equal_flag};
        K_TK:    act = {31'd0, branch_taken};
`ifdef ALU_OVERFLOW_EN
        K_OV:    act = {31'd0, overflow};
        K_OVQ:   act = {31'd0, overflow_q};
`endif
        default: act = 32'hDEAD_BEEF;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic pushQ(input string tag);
    push(K_Q, expQ, {tag, " alu_result_q"});
    push(K_ZQ, {31'd0, expZq}, {tag, " zero_q"});
`ifdef ALU_OVERFLOW_EN
    push(K_OVQ, {31'd0, expOq}, {tag, " overflow_q"});
`endif
  endtask

  task automatic aluVec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] res, input logic z,
                        input logic ov, input logic hold);
    @(posedge clk); #1;
    operand1 = a; operand2 = b; alu_control = op; ex_hold = hold;
    push(K_RES, res, {tag, " alu_result"});
    push(K_ZERO, {31'd0, z}, {tag, " zero"});
`ifdef ALU_OVERFLOW_EN
    push(K_OV, {31'd0, ov}, {tag, " overflow"});
`endif
    @(posedge clk); #1;
    if (!hold) begin
      expQ = res; expZq = z; expOq = ov;
    end
    pushQ(tag);
    ex_hold = 1'b0;
  endtask

  task automatic pcVec(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    @(posedge clk); #1;
    pc_in = pc;
    push(K_PC, exp, tag);
  endtask

  task automatic brVec(input string tag, input logic [31:0] p1, input logic [31:0] off,
                       input logic [31:0] exp);
    @(posedge clk); #1;
    pc_plus_one_id = p1; offset_ext = off;
    push(K_BA, exp, tag);
  endtask

  task automatic cmpVec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic eq, input logic tk);
    @(posedge clk); #1;
    cmp_a = a; cmp_b = b; branch = br;
    push(K_EQ, {31'd0, eq}, {tag, " equal_flag"});
    push(K_TK, {31'd0, tk}, {tag, " branch_taken"});
  endtask

  initial begin
    rst = 1'b1; ex_hold = 1'b0; branch = 1'b0; alu_control = ALU_ADD;
    operand1 = 32'd0; operand2 = 32'd0; pc_in = 32'd0; pc_plus_one_id = 32'd0;
    offset_ext = 32'd0; cmp_a = 32'd0; cmp_b = 32'd0;
    expQ = 32'd0; expZq = 1'b0; expOq = 1'b0;

    // Reset state: registers cleared, zero_q is 0 even though result is 0.
    @(posedge clk); #1;
    operand1 = 32'd5; operand2 = 32'd3;
    pushQ("reset");
    push(K_RES, 32'd8, "reset comb alu_result");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    aluVec("add 5+3",  32'd5,         32'd3,         ALU_ADD, 32'd8,         1'b0, 1'b0, 1'b0);
    aluVec("sub 5-3",  32'd5,         32'd3,         ALU_SUB, 32'd2,         1'b0, 1'b0, 1'b0);
    aluVec("sub 7-7",  32'd7,         32'd7,         ALU_SUB, 32'd0,         1'b1, 1'b0, 1'b0);
    aluVec("add wrap", 32'hFFFF_FFFF, 32'd1,         ALU_ADD, 32'd0,         1'b1, 1'b0, 1'b0);
    aluVec("and",      32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    aluVec("or",       32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR,  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    aluVec("add ovf",  32'h7FFF_FFFF, 32'd1,         ALU_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    aluVec("sub ovf",  32'h8000_0000, 32'd1,         ALU_SUB, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    aluVec("sub 3-1",  32'd3,         32'd1,         ALU_SUB, 32'd2,         1'b0, 1'b0, 1'b0);

    pcVec("pc+1 0xA", 32'h0000_000A, 32'h0000_000B);
    pcVec("pc+1 wrap", 32'hFFFF_FFFF, 32'h0000_0000);
    brVec("branch addr neg", 32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_000C);
    brVec("branch addr pos", 32'h0000_0100, 32'h0000_0020, 32'h0000_0120);

    cmpVec("cmp eq taken",  32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, 1'b1);
    cmpVec("cmp ne",        32'h0000_1234, 32'h0000_1235, 1'b1, 1'b0, 1'b0);
    cmpVec("cmp no branch", 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    cmpVec("cmp msb",       32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Mid-cycle reset: registers clear before the next edge, comb path unaffected.
    @(posedge clk); #1;
    operand1 = 32'd9; operand2 = 32'd9; alu_control = ALU_ADD;
    #2;
    rst = 1'b1;
    expQ = 32'd0; expZq = 1'b0; expOq = 1'b0;
    pushQ("mid reset");
    push(K_RES, 32'd18, "mid reset comb alu_result");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pushQ("reset release sync");
    repeat (3) @(posedge clk);

    aluVec("post reset add", 32'd2, 32'd2, ALU_ADD, 32'd4,  1'b0, 1'b0, 1'b0);
    aluVec("hold",           32'd9, 32'd1, ALU_ADD, 32'd10, 1'b0, 1'b0, 1'b1);
    aluVec("after hold",     32'd9, 32'd1, ALU_ADD, 32'd10, 1'b0, 1'b0, 1'b0);

    @(negedge clk); #1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_adder_comparator.md
Name: alu_adder_comparator

Overview:
- Execute/branch arithmetic block of the 5-stage pipelined MIPS core.
- Combines four functions:
  - the 32-bit ALU used in EX;
  - the PC-increment adder used in IF;
  - the branch-target adder used in ID;
  - the equality comparator used for early branch resolution in ID.
- All arithmetic results are combinational. The ALU result and zero flag are also captured in an output register that feeds the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width of operands, PC and results.
- PC_STEP, 1, PC increment; memory is word-addressed, so one word = 1.

Ports:
- clk  input  1  single clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- operand1  input  WIDTH  ALU operand A (after forwarding mux).
- operand2  input  WIDTH  ALU operand B (after ALUSrc mux).
- alu_control  input  2  ALU operation select.
- alu_result  output  WIDTH  combinational ALU result.
- zero  output  1  combinational; high when alu_result == 0.
- ex_hold  input  1  when high, the registered outputs keep their value.
- alu_result_q  output  WIDTH  registered alu_result.
- zero_q  output  1  registered zero.
- pc_in  input  WIDTH  current PC.
- pc_plus_one  output  WIDTH  pc_in + PC_STEP.
- pc_plus_one_id  input  WIDTH  PC+1 of the instruction in ID.
- offset_ext  input  WIDTH  sign-extended 16-bit immediate.
- branch_address  output  WIDTH  pc_plus_one_id + offset_ext.
- cmp_a  input  WIDTH  first comparator operand (forwarded rs value).
- cmp_b  input  WIDTH  second comparator operand (forwarded rt value).
- branch  input  1  branch instruction is in ID.
- equal_flag  output  1  cmp_a == cmp_b.
- branch_taken  output  1  branch AND equal_flag.

Behaviour:
- ALU operations, modulo 2^WIDTH, no traps:
  - alu_control 00: ADD, operand1 + operand2.
  - 01: SUB, operand1 - operand2 (two's complement).
  - 10: AND, bitwise.
  - 11: OR, bitwise.
- zero is the NOR-reduce of alu_result.
- Adders:
  - Plain WIDTH-bit unsigned sum; carry-out is discarded, results wrap.
  - No shift is applied to offset_ext (word addressing).
- Comparator:
  - Bitwise full-width equality; signedness is irrelevant.
  - branch_taken is combinational, with zero latency, for same-cycle PC mux select.
- Combinational outputs have no clock dependency and settle within the same cycle.
- Registered outputs:
  - On rst high, asynchronously: alu_result_q = 0, zero_q = 0.
  - On rising clk with rst low and ex_hold low: alu_result_q <= alu_result, zero_q <= zero.
  - With ex_hold high: hold the current value.
  - Latency is 1 cycle from operands to _q outputs.
- Reset asserted mid-operation clears the registers immediately. Combinational outputs are unaffected by rst.
- rst deassertion is internally synchronised (2-flop release) before it affects the registers.
- Simultaneous rst and ex_hold: rst wins.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output overflow (1 bit, combinational) and overflow_q (registered with the same reset/hold rules, reset value 0).
  - overflow is high for ADD when both operands have the same sign and the result sign differs.
  - overflow is high for SUB when the operands' signs differ and the result sign differs from operand1's sign.
  - overflow is 0 for AND/OR.
- Not defined: ports absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default;
  - ALU op constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - alu_op_t typedef.
- One sub-module wrap_adder (WIDTH-bit a+b). It is instantiated twice: PC increment and branch target.
- The ALU and comparator stay inline.

Test Plan:
- ADD/SUB: operand1=5, operand2=3. alu_control=00 -> alu_result=8, zero=0. alu_control=01 -> 2. Then operand1=operand2=7, SUB -> 0, zero=1.
- Wrap/logic: 0xFFFFFFFF ADD 1 -> 0, zero=1. 0xF0F0F0F0 AND 0x0FF00FF0 -> 0x00F000F0. Same operands OR -> 0xFFF0FFF0.
- Adders:
  - pc_in=0x0000000A -> pc_plus_one=0x0000000B.
  - pc_plus_one_id=0x10, offset_ext=0xFFFFFFFC -> branch_address=0x0C.
  - pc_in=0xFFFFFFFF -> pc_plus_one=0.
- Branch:
  - cmp_a=cmp_b=0x1234, branch=1 -> equal_flag=1, branch_taken=1.
  - cmp_b=0x1235 -> branch_taken=0.
  - branch=0 with equal operands -> branch_taken=0.
- Register/reset:
  - Assert rst mid-cycle -> alu_result_q=0, zero_q=0 immediately.
  - Release, ADD 2+2 -> alu_result_q=4 one edge later.
  - ex_hold=1 with new operands -> alu_result_q stays 4.
- ALU_OVERFLOW_EN:
  - 0x7FFFFFFF ADD 1 -> overflow=1.
  - 0x80000000 SUB 1 -> overflow=1.
  - 3 SUB 1 -> overflow=0.
